// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold row drive, 2-flop column sync, press/release debounce.
// Define KEYPAD_REPEAT_EN to add auto-repeat strobes while a key stays held.
module keypad_scanner #(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 100000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  localparam int MAX_AB = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int MAX_CD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int W      = $clog2(MAXP);

  localparam logic [W-1:0] DWELL_LAST = W'(SCAN_DIV - 1);
  localparam logic [W-1:0] DEB_LAST   = W'(DEBOUNCE_CNT - 1);

  state_t       state, state_next;
  logic [3:0]   sync1, col_s;
  logic [3:0]   pat, pat_next, row_next, code_next;
  logic [W-1:0] dwell, dwell_next, cnt, cnt_next;
  logic         valid_next, held_next;

`ifdef KEYPAD_REPEAT_EN
  localparam logic [W-1:0] REP_FIRST_LAST = W'(REPEAT_DELAY - 1);
  localparam logic [W-1:0] REP_RATE_LAST  = W'(REPEAT_RATE - 1);
  logic [W-1:0] rep, rep_next;
  logic         rep_on, rep_on_next, rep_first, rep_first_next;
`endif

  function automatic logic [1:0] low_col(input logic [3:0] c);
    if (!c[0])      return 2'd0;
    else if (!c[1]) return 2'd1;
    else if (!c[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] r);
    if (!r[0])      return 2'd0;
    else if (!r[1]) return 2'd1;
    else if (!r[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '1;
      col_s     <= '1;
      state     <= SCAN;
      row_out   <= 4'b1110;
      dwell     <= '0;
      cnt       <= '0;
      pat       <= '1;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep       <= '0;
      rep_on    <= 1'b0;
      rep_first <= 1'b0;
`endif
    end else begin
      sync1     <= col_in;
      col_s     <= sync1;
      state     <= state_next;
      row_out   <= row_next;
      dwell     <= dwell_next;
      cnt       <= cnt_next;
      pat       <= pat_next;
      key_code  <= code_next;
      key_valid <= valid_next;
      key_held  <= held_next;
`ifdef KEYPAD_REPEAT_EN
      rep       <= rep_next;
      rep_on    <= rep_on_next;
      rep_first <= rep_first_next;
`endif
    end
  end

  always_comb begin
    state_next = state;
    row_next   = row_out;
    dwell_next = dwell;
    cnt_next   = cnt;
    pat_next   = pat;
    code_next  = key_code;
    valid_next = 1'b0;
    held_next  = key_held;
`ifdef KEYPAD_REPEAT_EN
    rep_next       = rep;
    rep_on_next    = rep_on;
    rep_first_next = rep_first;
`endif
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_next = '0;
          if (col_s != 4'b1111) begin
            pat_next   = col_s;
            cnt_next   = '0;
            state_next = DEB_PRESS;
          end else begin
            row_next = {row_out[2:0], row_out[3]};
          end
        end else begin
          dwell_next = dwell + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (col_s == pat) begin
          if (cnt == DEB_LAST) begin
            code_next  = {row_index(row_out), low_col(pat)};
            valid_next = 1'b1;
            held_next  = 1'b1;
            cnt_next   = '0;
            state_next = HELD;
`ifdef KEYPAD_REPEAT_EN
            rep_next       = '0;
            rep_on_next    = 1'b1;
            rep_first_next = 1'b1;
`endif
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else begin
          cnt_next   = '0;
          dwell_next = '0;
          row_next   = {row_out[2:0], row_out[3]};
          state_next = SCAN;
        end
      end
      HELD: begin
        if (col_s == 4'b1111) begin
          cnt_next   = '0;
          state_next = DEB_REL;
`ifdef KEYPAD_REPEAT_EN
          rep_next    = '0;
          rep_on_next = 1'b0;
`endif
        end
`ifdef KEYPAD_REPEAT_EN
        // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE; bounce-backs from DEB_REL stay silent.
        else if (rep_on) begin
          if (rep == (rep_first ? REP_FIRST_LAST : REP_RATE_LAST)) begin
            valid_next     = 1'b1;
            rep_next       = '0;
            rep_first_next = 1'b0;
          end else begin
            rep_next = rep + 1'b1;
          end
        end
`endif
      end
      DEB_REL: begin
        if (col_s == 4'b1111) begin
          if (cnt == DEB_LAST) begin
            held_next  = 1'b0;
            cnt_next   = '0;
            dwell_next = '0;
            row_next   = {row_out[2:0], row_out[3]};
            state_next = SCAN;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end else begin
          cnt_next   = '0;
          state_next = HELD;
        end
      end
      default: state_next = SCAN;
    endcase
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives col_in from row_out, a cycle model
// predicts every output each cycle, and directed scenarios pin hand-computed results.
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DC = 16;
  localparam int RD = 64;
  localparam int RR = 32;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  col_in, row_out, key_code;
  logic        key_valid, key_held;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Each pressed key shorts its row to its column; only the driven (low) row can pull a column low.
  function automatic logic [3:0] cols_for(input logic [3:0] rows, input logic [15:0] k);
    logic [3:0] c;
    c = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (rows[r] === 1'b0)
        for (int cc = 0; cc < 4; cc++)
          if (k[r*4+cc]) c[cc] = 1'b0;
    return c;
  endfunction

  assign col_in = cols_for(row_out, keys);

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CNT(DC),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .col_in(col_in),
    .row_out(row_out),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  // ---------------- behavioural model ----------------
  localparam int M_SCAN = 0, M_PRESS = 1, M_HOLD = 2, M_REL = 3;

  int         m_row, m_dwell, m_cnt, m_age, m_mode;
  logic [3:0] m_s1, m_s2, m_pat, m_code;
  logic       m_valid, m_held, m_rep_on;
  logic       m_live = 1'b0;

  function automatic int first_low(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (!p[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    logic [3:0] seen_now, cs;
    seen_now = cols_for(~(4'b0001 << m_row), keys);
    cs = m_s2;
    if (reset) begin
      m_live <= 1'b1; m_row <= 0; m_dwell <= 0; m_cnt <= 0; m_age <= 0;
      m_mode <= M_SCAN; m_s1 <= 4'hF; m_s2 <= 4'hF; m_pat <= 4'hF;
      m_code <= 4'h0; m_valid <= 1'b0; m_held <= 1'b0; m_rep_on <= 1'b0;
    end else begin
      m_s1 <= seen_now;
      m_s2 <= m_s1;
      m_valid <= 1'b0;
      case (m_mode)
        M_SCAN:
          if (m_dwell == SD - 1) begin
            m_dwell <= 0;
            if (cs != 4'hF) begin
              m_pat <= cs; m_cnt <= 0; m_mode <= M_PRESS;
            end else m_row <= (m_row + 1) % 4;
          end else m_dwell <= m_dwell + 1;
        M_PRESS:
          if (cs == m_pat) begin
            if (m_cnt == DC - 1) begin
              m_code <= 4'(m_row * 4 + first_low(m_pat));
              m_valid <= 1'b1; m_held <= 1'b1; m_mode <= M_HOLD;
              m_rep_on <= 1'b1; m_age <= 0;
            end else m_cnt <= m_cnt + 1;
          end else begin
            m_mode <= M_SCAN; m_row <= (m_row + 1) % 4; m_dwell <= 0;
          end
        M_HOLD:
          if (cs == 4'hF) begin
            m_mode <= M_REL; m_cnt <= 0; m_rep_on <= 1'b0;
          end else if (REPEAT_ON && m_rep_on) begin
            // repeat instants measured from the acceptance strobe: RD, RD+RR, RD+2RR, ...
            m_age <= m_age + 1;
            if (m_age + 1 >= RD && (m_age + 1 - RD) % RR == 0) m_valid <= 1'b1;
          end
        M_REL:
          if (cs == 4'hF) begin
            if (m_cnt == DC - 1) begin
              m_held <= 1'b0; m_mode <= M_SCAN; m_row <= (m_row + 1) % 4; m_dwell <= 0;
            end else m_cnt <= m_cnt + 1;
          end else m_mode <= M_HOLD;
        default: m_mode <= M_SCAN;
      endcase
    end
  end

  task automatic chk(input string what, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", what, got, exp, $time);
    end
  endtask

  task automatic chk_int(input string what, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", what, got, exp, $time);
    end
  endtask

  // single compare process against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("model row_out", row_out, ~(4'b0001 << m_row));
      chk("model key_valid", {3'b000, key_valid}, {3'b000, m_valid});
      chk("model key_held", {3'b000, key_held}, {3'b000, m_held});
      chk("model key_code", key_code, m_code);
    end
  end

  // ---------------- directed stimulus ----------------
  int         seen = 0;
  logic [3:0] last_code = 4'h0;

  task automatic step();
    @(negedge clk);
    if (key_valid === 1'b1) begin
      seen++;
      last_code = key_code;
    end
  endtask

  task automatic wait_strobe(input string what, input int limit, output int took);
    int base;
    base = seen;
    took = 0;
    while (seen == base && took < limit) begin
      step();
      took++;
    end
    if (seen == base) chk_int({what, " strobe timeout"}, 0, 1);
  endtask

  task automatic wait_release(input string what, output int took);
    took = 0;
    while (key_held === 1'b1 && took < 200) begin
      step();
      took++;
    end
    chk({what, " held cleared"}, {3'b000, key_held}, 4'b0000);
  endtask

  int lat, base, n;
  int rep_at[$];
  logic [3:0] rot_exp [4];

  initial begin
    rot_exp[0] = 4'b1101; rot_exp[1] = 4'b1011; rot_exp[2] = 4'b0111; rot_exp[3] = 4'b1110;

    // 1: reset state, then free rotation every SD cycles with no strobe
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset row_out", row_out, 4'b1110);
    chk("reset key_valid", {3'b000, key_valid}, 4'b0000);
    chk("reset key_held", {3'b000, key_held}, 4'b0000);
    chk("reset key_code", key_code, 4'h0);
    for (int k = 0; k < 4; k++) begin
      repeat (SD) step();
      chk("idle rotation", row_out, rot_exp[k]);
    end
    chk_int("idle strobes", seen, 0);

    // 2: row 2 / col 1 -> code 9, held until release debounce completes
    keys = 16'h0001 << 9;
    wait_strobe("key9", 200, lat);
    chk("key9 code", last_code, 4'd9);
    chk("key9 frozen row", row_out, 4'b1011);
    n_checks++;
    if (lat > 4 * SD + DC + 3) begin
      n_fail++;
      $display("FAIL key9 latency: got %0d required at most %0d", lat, 4 * SD + DC + 3);
    end
    base = seen;
    repeat (20) step();
    chk("key9 still frozen", row_out, 4'b1011);
    chk("key9 held", {3'b000, key_held}, 4'b0001);
    chk_int("key9 single strobe", seen, base);
    keys = '0;
    wait_release("key9", n);
    // 2 sync flops + 1 cycle to leave HELD + DC stable cycles
    chk_int("key9 release cycles", n, 2 + 1 + DC);
    chk("key9 next row", row_out, 4'b0111);

    // 3: row 0 / col 3 for 10 cycles with a 1-cycle bounce -> abort, resume at row 1
    n = 0;
    while (row_out !== 4'b1110 && n < 200) begin step(); n++; end
    base = seen;
    repeat (3) step();
    keys = 16'h0008;
    repeat (5) step();
    keys = '0;
    step();
    keys = 16'h0008;
    step();
    chk("bounce frozen row", row_out, 4'b1110);
    step();
    chk("bounce resumed row", row_out, 4'b1101);
    repeat (2) step();
    keys = '0;
    repeat (40) step();
    chk_int("bounce no strobe", seen, base);
    chk("bounce not held", {3'b000, key_held}, 4'b0000);

    // 4: row 3 / col 0 held, second key ignored, then row 0 / col 0 alone
    keys = 16'h1000;
    wait_strobe("key12", 200, lat);
    chk("key12 code", last_code, 4'd12);
    keys = 16'h1001;
    base = seen;
    repeat (30) step();
    chk_int("rollover ignored", seen, base);
    chk("rollover code kept", key_code, 4'd12);
    keys = '0;
    wait_release("key12", n);
    chk("code kept after release", key_code, 4'd12);
    keys = 16'h0001;
    wait_strobe("key0", 200, lat);
    chk("key0 code", last_code, 4'd0);
    keys = '0;
    wait_release("key0", n);

    // 5: one-cycle reset while row 1 / col 2 is held -> defaults, then re-detected
    keys = 16'h0001 << 6;
    wait_strobe("key6", 200, lat);
    chk("key6 code", last_code, 4'd6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid reset row_out", row_out, 4'b1110);
    chk("mid reset key_held", {3'b000, key_held}, 4'b0000);
    chk("mid reset key_code", key_code, 4'd0);
    wait_strobe("key6 again", 200, lat);
    chk("key6 again code", last_code, 4'd6);
    keys = '0;
    wait_release("key6", n);

    // 6: row 1 / col 1 held 200 cycles after acceptance
    keys = 16'h0001 << 5;
    wait_strobe("key5", 200, lat);
    chk("key5 code", last_code, 4'd5);
    for (int t = 1; t <= 200; t++) begin
      step();
      if (key_valid === 1'b1) rep_at.push_back(t);
    end
    if (REPEAT_ON) begin
      chk_int("repeat count", rep_at.size(), 5);
      for (int i = 0; i < rep_at.size() && i < 5; i++)
        chk_int("repeat offset", rep_at[i], RD + i * RR);
    end else begin
      chk_int("no repeat", rep_at.size(), 0);
    end
    chk("key5 code kept", key_code, 4'd5);
    keys = '0;
    wait_release("key5", n);
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
